seg7_scan_display: RTL
======================

Name: seg7_scan_display

Overview:
Parametrised multi-digit seven-segment scanner. It is the successor of the two-digit BCD display path.
- Accepts an unsigned binary value on a load strobe and converts it to BCD with a sequential double-dabble.
- Time-multiplexes NUM_DIGITS digits onto shared active-low cathodes and per-digit active-low anodes.
- Supports optional leading-zero blanking and overflow indication.
- Sits between the design's arithmetic/value logic and the board's display pins.

Parameters:
NUM_DIGITS, 8, number of digits scanned; 1..8.
VAL_WIDTH, 16, width of the binary input value; 1..27.
SCAN_DIV, 100000, system clocks per digit dwell (1 kHz per digit at 100 MHz); minimum 2.

Ports:
clk_100MHz  in  1  system clock; all logic on its rising edge.
rst_n  in  1  synchronous active-low reset.
val  in  VAL_WIDTH  unsigned binary value to display.
load  in  1  single-cycle strobe; samples val when busy=0.
lz_blank  in  1  1 = blank leading zeros; sampled with val at load.
busy  out  1  conversion in progress.
ovf  out  1  displayed value exceeds 10^NUM_DIGITS-1.
cathodes  out  7  active-low segments, bit0=a ... bit6=g.
anodes  out  NUM_DIGITS  active-low digit enables; bit0 = least-significant digit.

Behaviour:
- Reset (rst_n=0 at a clock edge): outputs and state go to the following values.
  - busy=0, ovf=0, cathodes=7'h7F, anodes=all 1.
  - Display BCD register=0, stored blank flag=0.
  - Prescaler=SCAN_DIV-1, scan index=0.
  - Reset asserted mid-conversion aborts it; the display is not updated.
- Load:
  - If load=1 and busy=0, capture val, lz_blank and ovf_next=(val > 10^NUM_DIGITS-1).
  - Set busy=1 on the next cycle.
  - Load while busy=1 is ignored; no queuing.
- Conversion: FSM states IDLE, SHIFT, DONE.
  - SHIFT runs exactly VAL_WIDTH cycles, one bit per cycle, MSB first.
  - Each cycle, every BCD nibble >=5 gets +3, then the whole register shifts left 1.
  - The working register is NUM_DIGITS+1 digits wide.
  - DONE lasts one cycle. In it the low NUM_DIGITS digits, the blank flag and ovf are copied atomically into the display registers, and busy returns to 0.
  - load-to-busy-falling latency is VAL_WIDTH+2 cycles.
  - A new load is accepted on the cycle busy reads 0.
- Scan:
  - The prescaler counts down every cycle. At 0 it reloads SCAN_DIV-1 and the scan index increments.
  - The index wraps NUM_DIGITS-1 to 0.
  - Anodes and cathodes are registered and update together on the cycle after the index changes.
  - Exactly one anode is low at any time after the first post-reset tick.
  - Scanning is independent of conversion; a display update takes effect at the next digit dwell.
- Digit decode: 0-9 map to standard patterns, a..g active-low. Examples: 0=7'h40, 1=7'h79, 8=7'h00.
  - Nibbles >9 are unreachable by construction; they decode to 7'h7F (blank) as a safety default.
- Leading-zero blanking: when the stored blank flag=1, digit i (i>0) shows 7'h7F if digits i..NUM_DIGITS-1 are all zero. Digit 0 is never blanked.
- Overflow: if stored ovf=1, every digit shows dash 7'h3F and the ovf output is 1. Blanking is ignored.
- Anode pin stays low for the blanked digit; only cathodes blank.

Test Plan:
1. NUM_DIGITS=4, VAL_WIDTH=16, SCAN_DIV=4; release reset, no load.
   -> anodes cycle 1110,1101,1011,0111 every 4 clocks.
   -> cathodes=7'h40 on every digit.
   -> busy=0, ovf=0.
2. load val=1234, lz_blank=0.
   -> busy high for 18 cycles after the load edge.
   -> subsequent scan shows digit0=4 (7'h19), digit1=3 (7'h30), digit2=2 (7'h24), digit3=1 (7'h79).
3. load val=7, lz_blank=1.
   -> digit0=7'h78; digits1-3=7'h7F while their anodes still go low in turn.
4. load val=10000 (exceeds 9999).
   -> ovf=1 after DONE; all four digits show 7'h3F.
   -> then load 0 -> ovf=0 and display 0000.
5. load val=42, then load val=99 two cycles later while busy.
   -> second load ignored; display shows 0042 (or 42 with blanking).
   -> after busy falls, load 99 -> display 0099.
6. Assert rst_n=0 at cycle 5 of a conversion of 5555.
   -> next edge: anodes all 1, busy=0, display register 0.
   -> after release, display shows 0000, not 5555.

Source files
------------

// File: rtl/seg7_scan_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : seg7_scan_display                                          |
// | Description : Binary-to-BCD (sequential double-dabble) converter feeding |
// |               a time-multiplexed, active-low seven-segment scanner with  |
// |               leading-zero blanking and overflow dashes.                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module seg7_scan_display #(
    parameter int NUM_DIGITS = 8,
    parameter int VAL_WIDTH  = 16,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                  clk_100MHz,
    input  logic                  rst_n,
    input  logic [VAL_WIDTH-1:0]  val,
    input  logic                  load,
    input  logic                  lz_blank,
    output logic                  busy,
    output logic                  ovf,
    output logic [6:0]            cathodes,
    output logic [NUM_DIGITS-1:0] anodes
);

    // The working register carries one spare digit so values up to
    // 10*10^NUM_DIGITS-1 convert without wrapping; overflow is judged from
    // the binary input, so the spare digit is never displayed.
    localparam int c_bcd_digits = NUM_DIGITS + 1;
    localparam int c_bcd_w      = 4 * c_bcd_digits;
    localparam int c_disp_w     = 4 * NUM_DIGITS;
    localparam int c_cnt_w      = $clog2(VAL_WIDTH + 1);
    localparam int c_pre_w      = $clog2(SCAN_DIV);
    localparam int c_idx_w      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [31:0]           c_max_val  = 32'(10 ** NUM_DIGITS - 1);
    localparam logic [c_cnt_w-1:0]    c_last_bit = c_cnt_w'(VAL_WIDTH - 1);
    localparam logic [c_pre_w-1:0]    c_pre_load = c_pre_w'(SCAN_DIV - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one_hot  = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;
    logic   w_accept;
    logic   w_do_shift;
    logic   w_commit;

    logic [VAL_WIDTH-1:0] r_shift;
    logic [c_bcd_w-1:0]   r_bcd;
    logic [c_bcd_w-1:0]   w_bcd_adj;
    logic [c_cnt_w-1:0]   r_bit_cnt;
    logic                 r_blank_next;
    logic                 r_ovf_next;

    logic [c_disp_w-1:0]  r_disp;
    logic                 r_disp_blank;

    logic [c_pre_w-1:0]   r_presc;
    logic [c_idx_w-1:0]   r_idx;
    logic                 r_adv;

    logic [3:0]           w_digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] w_hi_zero;
    logic [6:0]           w_seg;

    // Active-low glyphs, bit0 = a ... bit6 = g; non-decimal nibbles blank.
    function automatic logic [6:0] f_glyph(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'd0:    seg = 7'h40;
            4'd1:    seg = 7'h79;
            4'd2:    seg = 7'h24;
            4'd3:    seg = 7'h30;
            4'd4:    seg = 7'h19;
            4'd5:    seg = 7'h12;
            4'd6:    seg = 7'h02;
            4'd7:    seg = 7'h78;
            4'd8:    seg = 7'h00;
            4'd9:    seg = 7'h10;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // Conversion FSM state register.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-state control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_do_shift   = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            S_IDLE: begin
                // busy lingers one cycle after DONE, so IDLE alone is not enough.
                if (load && !busy) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_do_shift = 1'b1;
                if (r_bit_cnt == c_last_bit) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_commit     = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Double-dabble correction: every nibble of 5 or more gets +3 before the shift.
    for (genvar i = 0; i < c_bcd_digits; i++) begin : g_dabble
        assign w_bcd_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? (r_bcd[4*i +: 4] + 4'd3)
                                                                : r_bcd[4*i +: 4];
    end

    // Conversion datapath, display registers and busy/ovf flags.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            r_shift      <= '0;
            r_bcd        <= '0;
            r_bit_cnt    <= '0;
            r_blank_next <= 1'b0;
            r_ovf_next   <= 1'b0;
            r_disp       <= '0;
            r_disp_blank <= 1'b0;
            ovf          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            // busy covers SHIFT and DONE plus one settle cycle after the commit.
            busy <= w_accept || (r_state != S_IDLE);
            if (w_accept) begin
                r_shift      <= val;
                r_bcd        <= '0;
                r_bit_cnt    <= '0;
                r_blank_next <= lz_blank;
                r_ovf_next   <= (32'(val) > c_max_val);
            end
            if (w_do_shift) begin
                r_bcd     <= (w_bcd_adj << 1) | {{(c_bcd_w-1){1'b0}}, r_shift[VAL_WIDTH-1]};
                r_shift   <= r_shift << 1;
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
            if (w_commit) begin
                r_disp       <= r_bcd[c_disp_w-1:0];
                r_disp_blank <= r_blank_next;
                ovf          <= r_ovf_next;
            end
        end
    end

    // Per-digit view of the display register and "this digit and all above are zero".
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digits
        assign w_digits[i]  = r_disp[4*i +: 4];
        assign w_hi_zero[i] = (r_disp[c_disp_w-1:4*i] == '0);
    end

    // Segment pattern for the digit currently selected by the scan index.
    always_comb begin
        w_seg = 7'h7F;
        if (ovf) begin
            w_seg = 7'h3F;
        end else if (r_disp_blank && (r_idx != '0) && w_hi_zero[r_idx]) begin
            w_seg = 7'h7F;
        end else begin
            w_seg = f_glyph(w_digits[r_idx]);
        end
    end

    // Dwell prescaler and scan index; r_adv flags the cycle after an index change.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            r_presc <= c_pre_load;
            r_idx   <= '0;
            r_adv   <= 1'b0;
        end else begin
            r_adv <= 1'b0;
            if (r_presc == '0) begin
                r_presc <= c_pre_load;
                r_adv   <= 1'b1;
                r_idx   <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
            end else begin
                r_presc <= r_presc - 1'b1;
            end
        end
    end

    // Pin registers: anode and cathodes change together at the start of each dwell.
    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            anodes   <= '1;
            cathodes <= 7'h7F;
        end else if (r_adv) begin
            anodes   <= ~(c_one_hot << r_idx);
            cathodes <= w_seg;
        end
    end

endmodule
`default_nettype wire
